datapath_sequencer: RTL and testbench

- Micro-program sequencer that drives the register-file/ALU datapath control inputs (Wen, WA, RAA, RAB, Op) from a small internal program memory.
- Loaded through a write port, started by a one-cycle start pulse.
- Executes ALU writes, flag-producing compares and conditional branches on the datapath Flag.
- Reports busy/done/err to the system controller; contains a step watchdog against runaway loops.

---
 rtl/datapath_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_datapath_sequencer.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_sequencer.sv
// datapath_sequencer
// ------------------
// Micro-program sequencer for the register-file/ALU datapath. A small program
// memory is loaded through a write port; a one-cycle start pulse runs it from
// pc=0. Each instruction is fetched (FETCH), then executed (EXEC). A compare
// spends one extra cycle (FLAGW) so the datapath Flag can be captured.
// A step watchdog aborts runaway programs.
//
// Handshake: start is a single-cycle request accepted only in IDLE (busy=0).
// busy stays high from the cycle after an accepted start through the DONE
// cycle. done is a one-cycle pulse in that final cycle. prog_we is honoured
// only while busy=0; a write while busy is dropped and sets the sticky err.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   prog_we/addr/data program memory write port
//   start             launch program at pc=0
//   Flag              datapath flag, sampled in FLAGW
//   Wen, WA, RAA, RAB, Op   datapath control outputs
//   busy, done, err   status to the system controller
//   pc_o              current program counter
//
// Instruction word [17:0], type in [17:16]:
//   00 ALU : Op[15:13] WA[12:9] RAA[8:5] RAB[4:1]
//   01 CMP : Op[15:13] RAA[8:5] RAB[4:1]
//   10 BRF : pol[4] target[3:0], taken when flag_q == pol
//   11 HALT
module datapath_sequencer #(
  parameter int PROG_DEPTH = 16,
  parameter int MAX_STEPS  = 255,
  localparam int PW = $clog2(PROG_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_we,
  input  logic [PW-1:0] prog_addr,
  input  logic [17:0]   prog_data,
  input  logic          start,
  input  logic          Flag,
  output logic          Wen,
  output logic [3:0]    WA,
  output logic [3:0]    RAA,
  output logic [3:0]    RAB,
  output logic [2:0]    Op,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [PW-1:0] pc_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_FLAGW = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [1:0]  T_ALU  = 2'b00;
  localparam logic [1:0]  T_CMP  = 2'b01;
  localparam logic [1:0]  T_BRF  = 2'b10;
  localparam logic [17:0] HALT_W = 18'h3FFFF;
  localparam logic [8:0]  MAX_C  = 9'(MAX_STEPS);

  state_t        state_q, state_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [7:0]    step_q, step_d;
  logic [1:0]    ir_type_q, ir_type_d;
  logic          br_pol_q, br_pol_d;
  logic [PW-1:0] br_tgt_q, br_tgt_d;
  logic          flag_q, flag_d;
  logic          err_q, err_d;
  logic [2:0]    op_q, op_d;
  logic [3:0]    wa_q, wa_d;
  logic [3:0]    raa_q, raa_d;
  logic [3:0]    rab_q, rab_d;
  logic [17:0]   mem_q [PROG_DEPTH];
  logic [17:0]   mem_d [PROG_DEPTH];
  logic [17:0]   fetch_w;
  logic          wd_hit;

  // The watchdog fires on the EXEC whose step count would reach MAX_STEPS;
  // a HALT at that point still completes normally.
  assign wd_hit = (state_q == S_EXEC) && (ir_type_q != 2'b11) &&
                  (({1'b0, step_q} + 9'd1) == MAX_C);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    step_d    = step_q;
    ir_type_d = ir_type_q;
    br_pol_d  = br_pol_q;
    br_tgt_d  = br_tgt_q;
    flag_d    = flag_q;
    err_d     = err_q;
    op_d      = op_q;
    wa_d      = wa_q;
    raa_d     = raa_q;
    rab_d     = rab_q;
    mem_d     = mem_q;
    fetch_w   = mem_q[pc_q];

    if (prog_we && (state_q == S_IDLE)) begin
      mem_d[prog_addr] = prog_data;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
          step_d  = '0;
          err_d   = 1'b0;
        end
      end
      S_FETCH: begin
        ir_type_d = fetch_w[17:16];
        br_pol_d  = fetch_w[4];
        br_tgt_d  = fetch_w[PW-1:0];
        // Control fields are captured here so they are stable for all of
        // EXEC; BRF/HALT leave the previous values in place.
        if (fetch_w[17:16] == T_ALU) begin
          op_d  = fetch_w[15:13];
          wa_d  = fetch_w[12:9];
          raa_d = fetch_w[8:5];
          rab_d = fetch_w[4:1];
        end else if (fetch_w[17:16] == T_CMP) begin
          op_d  = fetch_w[15:13];
          raa_d = fetch_w[8:5];
          rab_d = fetch_w[4:1];
        end
        state_d = S_EXEC;
      end
      S_EXEC: begin
        step_d = step_q + 8'd1;
        if (wd_hit) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          case (ir_type_q)
            T_ALU: begin
              pc_d    = pc_q + PW'(1);
              state_d = S_FETCH;
            end
            T_CMP: begin
              state_d = S_FLAGW;
            end
            T_BRF: begin
              pc_d    = (flag_q == br_pol_q) ? br_tgt_q : pc_q + PW'(1);
              state_d = S_FETCH;
            end
            default: begin
              state_d = S_DONE;
            end
          endcase
        end
      end
      S_FLAGW: begin
        flag_d  = Flag;
        pc_d    = pc_q + PW'(1);
        state_d = S_FETCH;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (prog_we && (state_q != S_IDLE)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      step_q    <= '0;
      ir_type_q <= 2'b11;
      br_pol_q  <= 1'b0;
      br_tgt_q  <= '0;
      flag_q    <= 1'b0;
      err_q     <= 1'b0;
      op_q      <= '0;
      wa_q      <= '0;
      raa_q     <= '0;
      rab_q     <= '0;
      for (int i = 0; i < PROG_DEPTH; i++) begin
        mem_q[i] <= HALT_W;
      end
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      step_q    <= step_d;
      ir_type_q <= ir_type_d;
      br_pol_q  <= br_pol_d;
      br_tgt_q  <= br_tgt_d;
      flag_q    <= flag_d;
      err_q     <= err_d;
      op_q      <= op_d;
      wa_q      <= wa_d;
      raa_q     <= raa_d;
      rab_q     <= rab_d;
      mem_q     <= mem_d;
    end
  end

  // Wen is decoded from state so an asynchronous reset drops it immediately.
  assign Wen  = (state_q == S_EXEC) && (ir_type_q == T_ALU) && !wd_hit;
  assign WA   = wa_q;
  assign RAA  = raa_q;
  assign RAB  = rab_q;
  assign Op   = op_q;
  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign err  = err_q;
  assign pc_o = pc_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Testbench for datapath_sequencer: directed scenarios plus randomized
// programs, each checked against an instruction-level reference model.
module tb_datapath_sequencer;

  localparam int MAXS = 255;
  localparam logic [17:0] HALT = 18'h3FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [17:0] prog_data;
  logic        start;
  logic        Flag;
  logic        Wen;
  logic [3:0]  WA, RAA, RAB;
  logic [2:0]  Op;
  logic        busy, done, err;
  logic [3:0]  pc_o;

  datapath_sequencer dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .Flag(Flag), .Wen(Wen),
    .WA(WA), .RAA(RAA), .RAB(RAB), .Op(Op), .busy(busy), .done(done),
    .err(err), .pc_o(pc_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model state ----------------
  logic [17:0] mdl_mem [16];
  logic        mdl_flag;
  logic [14:0] exp_q[$];      // expected {Op,WA,RAA,RAB} per register write
  int          exp_pcs[$];    // expected sequence of distinct fetched pcs
  int          exp_cycles;
  int          exp_pc;
  logic        exp_err;

  function automatic logic [17:0] alu(input logic [2:0] op, input logic [3:0] wa,
                                      input logic [3:0] ra, input logic [3:0] rb);
    return {2'b00, op, wa, ra, rb, 1'b0};
  endfunction

  function automatic logic [17:0] cmp(input logic [2:0] op, input logic [3:0] ra,
                                      input logic [3:0] rb);
    return {2'b01, op, 4'b0000, ra, rb, 1'b0};
  endfunction

  function automatic logic [17:0] brf(input logic pol, input logic [3:0] tgt);
    return {2'b10, 11'd0, pol, tgt};
  endfunction

  // Interprets the program one instruction at a time. Cycle cost:
  // ALU/BRF/HALT 2, CMP 3; done comes one cycle after the last instruction.
  task automatic model_run(input logic flag_val);
    int pc;
    int steps;
    logic [17:0] w;
    exp_q.delete();
    exp_pcs.delete();
    pc = 0;
    steps = 0;
    exp_cycles = 0;
    exp_err = 1'b0;
    for (int g = 0; g < 1000; g++) begin
      w = mdl_mem[pc];
      if (exp_pcs.size() == 0 || exp_pcs[$] != pc) exp_pcs.push_back(pc);
      steps++;
      exp_cycles += 2;
      if (w[17:16] == 2'b11) break;
      if (steps == MAXS) begin
        exp_err = 1'b1;
        break;
      end
      case (w[17:16])
        2'b00: begin
          exp_q.push_back({w[15:13], w[12:9], w[8:5], w[4:1]});
          pc = (pc + 1) % 16;
        end
        2'b01: begin
          exp_cycles += 1;
          mdl_flag = flag_val;
          pc = (pc + 1) % 16;
        end
        default: begin
          pc = (mdl_flag == w[4]) ? int'(w[3:0]) : (pc + 1) % 16;
        end
      endcase
    end
    exp_pc = pc;
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_word(input logic [3:0] a, input logic [17:0] d);
    @(posedge clk); #1;
    prog_we = 1'b1;
    prog_addr = a;
    prog_data = d;
    @(posedge clk); #1;
    prog_we = 1'b0;
    mdl_mem[a] = d;
  endtask

  // Starts the loaded program and scores it against the model. Optional
  // extras: a write coincident with start, a write injected while busy at
  // cycle inj_cyc, and random start pulses while busy (must be ignored).
  task automatic run_program(input logic flag_val, input int inj_cyc,
                             input logic sim_we, input logic [3:0] sim_addr,
                             input logic [17:0] sim_data, input logic start_noise,
                             output int wen_cnt, output int first_wen);
    int cyc;
    int prev_pc;
    logic got_done;
    logic [14:0] exp_w;
    logic [14:0] act_w;
    int act_pcs[$];
    logic trace_ok;
    if (sim_we) mdl_mem[sim_addr] = sim_data;
    model_run(flag_val);
    if (inj_cyc > 0) exp_err = 1'b1;
    wen_cnt = 0;
    first_wen = -1;
    prev_pc = -1;
    got_done = 1'b0;
    Flag = flag_val;
    @(posedge clk); #1;
    start = 1'b1;
    prog_we = sim_we;
    prog_addr = sim_addr;
    prog_data = sim_data;
    @(posedge clk); #1;
    start = 1'b0;
    prog_we = 1'b0;
    cyc = 1;
    while (!got_done && cyc <= 2000) begin
      if (cyc == inj_cyc) begin
        prog_we = 1'b1;
        prog_addr = 4'd7;
        prog_data = {2'b00, 16'($urandom)};
      end
      if (start_noise && cyc > 1) start = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      if (cyc == 1) begin
        n_vec++;
        if (err !== 1'b0 || busy !== 1'b1) begin
          n_err++;
          $display("FAIL start_accept: err=%b busy=%b, expected err=0 busy=1", err, busy);
        end
      end
      if (busy === 1'b1 && int'(pc_o) != prev_pc) begin
        act_pcs.push_back(int'(pc_o));
        prev_pc = int'(pc_o);
      end
      if (Wen === 1'b1) begin
        wen_cnt++;
        if (first_wen < 0) first_wen = cyc;
        act_w = {Op, WA, RAA, RAB};
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL wen_unexpected: write %h at cycle %0d, expected no write", act_w, cyc);
        end else begin
          exp_w = exp_q.pop_front();
          if (act_w !== exp_w) begin
            n_err++;
            $display("FAIL wen_fields: {Op,WA,RAA,RAB}=%h, expected %h", act_w, exp_w);
          end
        end
      end
      if (done === 1'b1) got_done = 1'b1;
      else begin
        @(posedge clk); #1;
        prog_we = 1'b0;
        start = 1'b0;
        cyc++;
      end
    end
    start = 1'b0;
    prog_we = 1'b0;
    n_vec++;
    if (!got_done) begin
      n_err++;
      $display("FAIL done_timeout: no done within %0d cycles, expected at cycle %0d", cyc, exp_cycles + 1);
    end else if (cyc != exp_cycles + 1) begin
      n_err++;
      $display("FAIL done_latency: done at cycle %0d, expected %0d", cyc, exp_cycles + 1);
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL wen_missing: %0d writes missing, expected 0", exp_q.size());
    end
    trace_ok = (act_pcs.size() == exp_pcs.size());
    if (trace_ok) begin
      foreach (act_pcs[i]) if (act_pcs[i] != exp_pcs[i]) trace_ok = 1'b0;
    end
    n_vec++;
    if (!trace_ok) begin
      n_err++;
      $display("FAIL pc_trace: %0d pcs ending %0d, expected %0d pcs ending %0d",
               act_pcs.size(), (act_pcs.size() > 0) ? act_pcs[$] : -1,
               exp_pcs.size(), exp_pcs[$]);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || Wen !== 1'b0 || err !== exp_err ||
        int'(pc_o) != exp_pc) begin
      n_err++;
      $display("FAIL end_state: busy=%b done=%b Wen=%b err=%b pc=%0d, expected 0 0 0 %b %0d",
               busy, done, Wen, err, pc_o, exp_err, exp_pc);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    n_vec++;
    if (Wen !== 1'b0 || WA !== 4'd0 || RAA !== 4'd0 || RAB !== 4'd0 || Op !== 3'd0) begin
      n_err++;
      $display("FAIL reset_ctrl: Wen=%b WA=%h RAA=%h RAB=%h Op=%h, expected all 0", Wen, WA, RAA, RAB, Op);
    end
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || pc_o !== 4'd0) begin
      n_err++;
      $display("FAIL reset_status: busy=%b done=%b err=%b pc=%h, expected all 0", busy, done, err, pc_o);
    end
  endtask

  task automatic test_alu_basic();
    int wc, fw;
    load_word(4'd0, alu(3'b000, 4'd3, 4'd1, 4'd2));
    load_word(4'd1, HALT);
    run_program(1'b0, 0, 1'b0, 4'd0, 18'd0, 1'b0, wc, fw);
    n_vec++;
    if (wc != 1 || fw != 2) begin
      n_err++;
      $display("FAIL alu_basic: %0d pulses first at cycle %0d, expected 1 at cycle 2", wc, fw);
    end
  endtask

  task automatic test_branch();
    int wc, fw;
    load_word(4'd0, cmp(3'b010, 4'd4, 4'd5));
    load_word(4'd1, brf(1'b1, 4'd6));
    load_word(4'd2, HALT);
    load_word(4'd6, HALT);
    run_program(1'b1, 0, 1'b0, 4'd0, 18'd0, 1'b0, wc, fw);
    n_vec++;
    if (pc_o !== 4'd6) begin
      n_err++;
      $display("FAIL branch_taken: pc=%0d, expected 6", pc_o);
    end
    run_program(1'b0, 0, 1'b0, 4'd0, 18'd0, 1'b0, wc, fw);
    n_vec++;
    if (pc_o !== 4'd2) begin
      n_err++;
      $display("FAIL branch_not_taken: pc=%0d, expected 2", pc_o);
    end
  endtask

  task automatic test_watchdog();
    int wc, fw;
    load_word(4'd0, brf(1'b0, 4'd0));
    run_program(1'b0, 0, 1'b0, 4'd0, 18'd0, 1'b0, wc, fw);
    n_vec++;
    if (wc != 0 || err !== 1'b1) begin
      n_err++;
      $display("FAIL watchdog: Wen pulses=%0d err=%b, expected 0 and 1", wc, err);
    end
  endtask

  task automatic test_busy_write();
    int wc, fw;
    for (int i = 0; i < 7; i++) load_word(4'(i), {2'b00, 16'($urandom)});
    load_word(4'd7, HALT);
    run_program(1'b0, 2, 1'b0, 4'd0, 18'd0, 1'b0, wc, fw);
    repeat (3) @(negedge clk);
    n_vec++;
    if (err !== 1'b1) begin
      n_err++;
      $display("FAIL err_sticky: err=%b, expected 1", err);
    end
    run_program(1'b1, 0, 1'b0, 4'd0, 18'd0, 1'b0, wc, fw);
    n_vec++;
    if (wc != 7 || pc_o !== 4'd7) begin
      n_err++;
      $display("FAIL busy_write_dropped: %0d writes pc=%0d, expected 7 writes pc=7", wc, pc_o);
    end
  endtask

  task automatic test_reset_mid_run();
    int wc, fw;
    for (int i = 0; i < 16; i++) load_word(4'(i), {2'b00, 16'($urandom)});
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (Wen !== 1'b1 || pc_o !== 4'd2) begin
      n_err++;
      $display("FAIL pre_reset: Wen=%b pc=%0d, expected 1 and 2", Wen, pc_o);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (Wen !== 1'b0 || busy !== 1'b0 || pc_o !== 4'd0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: Wen=%b busy=%b pc=%0d done=%b, expected 0 0 0 0", Wen, busy, pc_o, done);
    end
    #1 rst = 1'b0;
    for (int i = 0; i < 16; i++) mdl_mem[i] = HALT;
    mdl_flag = 1'b0;
    run_program(1'b0, 0, 1'b0, 4'd0, 18'd0, 1'b0, wc, fw);
  endtask

  task automatic test_halt_at_2();
    int wc, fw;
    for (int i = 0; i < 16; i++)
      load_word(4'(i), (i == 2) ? HALT : {2'b00, 16'($urandom)});
    run_program(1'b0, 0, 1'b0, 4'd0, 18'd0, 1'b0, wc, fw);
    n_vec++;
    if (wc != 2 || pc_o !== 4'd2) begin
      n_err++;
      $display("FAIL halt_at_2: %0d writes pc=%0d, expected 2 writes pc=2", wc, pc_o);
    end
  endtask

  task automatic test_wrap();
    int wc, fw;
    load_word(4'd2, alu(3'b101, 4'd9, 4'd8, 4'd7));
    run_program(1'b0, 0, 1'b0, 4'd0, 18'd0, 1'b0, wc, fw);
    n_vec++;
    if (wc != MAXS - 1 || pc_o !== 4'd14 || err !== 1'b1) begin
      n_err++;
      $display("FAIL wrap: %0d writes pc=%0d err=%b, expected %0d writes pc=14 err=1",
               wc, pc_o, err, MAXS - 1);
    end
  endtask

  task automatic test_start_and_write();
    int wc, fw;
    run_program(1'b0, 0, 1'b1, 4'd0, HALT, 1'b0, wc, fw);
    n_vec++;
    if (wc != 0) begin
      n_err++;
      $display("FAIL start_and_write: %0d writes, expected 0", wc);
    end
  endtask

  task automatic test_random();
    int wc, fw;
    int r;
    logic [17:0] w;
    for (int run = 0; run < 8; run++) begin
      for (int i = 0; i < 16; i++) begin
        r = $urandom_range(0, 9);
        if (r < 4)      w = {2'b00, 16'($urandom)};
        else if (r < 6) w = {2'b01, 16'($urandom)};
        else if (r < 8) w = brf(1'($urandom), 4'($urandom));
        else            w = HALT;
        load_word(4'(i), w);
      end
      run_program(1'($urandom), (run == 3) ? 2 : 0, 1'b0, 4'd0, 18'd0, 1'b1, wc, fw);
    end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    rst = 1'b1;
    prog_we = 1'b0;
    prog_addr = 4'd0;
    prog_data = 18'd0;
    start = 1'b0;
    Flag = 1'b0;
    for (int i = 0; i < 16; i++) mdl_mem[i] = HALT;
    mdl_flag = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_alu_basic();
    test_branch();
    test_watchdog();
    test_busy_write();
    test_reset_mid_run();
    test_halt_at_2();
    test_wrap();
    test_start_and_write();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
